// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the slide-switch debouncer: FSM state encoding and default sizing.
package sw_debounce_pkg;

  localparam int unsigned N_SW_DEF            = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HIGH   = 2'd2,
    ST_CHK_LO = 2'd3
  } sw_state_t;

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-FF synchroniser, qualify FSM with stability counter,
// registered level, rise/fall pulses and rise-driven toggle.
module sw_debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_db,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_tog
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  sw_state_t        r_state;
  sw_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_db;
  logic             r_rise;
  logic             r_fall;
  logic             r_tog;
  logic             w_db_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic             w_tog_nxt;

  // Synchroniser; only r_s2 is seen by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= sw_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_db    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_tog   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_db    <= w_db_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_tog   <= w_tog_nxt;
    end
  end

  // Pulses default low so each lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_db_nxt    = r_db;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_tog_nxt   = r_tog;
    unique case (r_state)
      ST_LOW: begin
        if (r_s2) begin
          w_state_nxt = ST_CHK_HI;
          w_cnt_nxt   = '0;
        end
      end
      ST_CHK_HI: begin
        if (!r_s2) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
          w_db_nxt    = 1'b1;
          w_rise_nxt  = 1'b1;
          w_tog_nxt   = ~r_tog;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!r_s2) begin
          w_state_nxt = ST_CHK_LO;
          w_cnt_nxt   = '0;
        end
      end
      ST_CHK_LO: begin
        if (r_s2) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = '0;
          w_db_nxt    = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign sw_db   = r_db;
  assign sw_rise = r_rise;
  assign sw_fall = r_fall;
  assign sw_tog  = r_tog;

endmodule : sw_debounce_ch

// File: rtl/sw_debounce.sv
// Slide-switch conditioning: N_SW independent debounce channels feeding the LED logic.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned N_SW            = N_SW_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic [N_SW-1:0] sw_tog
);

  for (genvar g = 0; g < N_SW; g++) begin : g_ch
    sw_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_raw (sw_raw[g]),
      .sw_db  (sw_db[g]),
      .sw_rise(sw_rise[g]),
      .sw_fall(sw_fall[g]),
      .sw_tog (sw_tog[g])
    );
  end

endmodule : sw_debounce
